// File: rtl/thread_state_pkg.sv
// Shared md5crypt thread-state encodings and the thread-number width helper.
package thread_state_pkg;

    localparam int THREAD_STATE_MSB = 1;

    localparam logic [THREAD_STATE_MSB:0] THREAD_STATE_NONE   = 2'd0;
    localparam logic [THREAD_STATE_MSB:0] THREAD_STATE_WR_RDY = 2'd1;
    localparam logic [THREAD_STATE_MSB:0] THREAD_STATE_RD_RDY = 2'd2;
    localparam logic [THREAD_STATE_MSB:0] THREAD_STATE_BUSY   = 2'd3;

    // MSB index needed to hold the value v (at least bit 0).
    function automatic int msb(input int v);
        return (v <= 1) ? 0 : $clog2(v + 1) - 1;
    endfunction

endpackage

// File: rtl/thread_state_next.sv
// Thread-number successor: walks threads core-interleaved (stride N_CORES),
// wraps to 0 and never yields a number >= N_THREADS.
module next_thread_num #(
    parameter int N_CORES       = 1,
    parameter int N_THREADS     = 8,
    parameter int N_THREADS_MSB = 2
) (
    input  logic [N_THREADS_MSB:0] i_num,
    output logic [N_THREADS_MSB:0] o_next
);

    localparam int NUM_W = N_THREADS_MSB + 1;

    int w_step;

    always_comb begin
        w_step = 32'(i_num) + N_CORES;
        // End of one core's stride: move to the next core's first thread.
        if (w_step >= N_THREADS) begin
            w_step = (32'(i_num) % N_CORES) + 1;
            if (w_step >= N_CORES || w_step >= N_THREADS)
                w_step = 0;
        end
        o_next = NUM_W'(w_step);
    end

endmodule

// File: rtl/thread_state.sv
// Per-thread state RAM for one md5crypt CPU: init walk, CPU/unit write merge,
// registered look-ahead read and a round-robin RD_RDY scanner.
module thread_state
    import thread_state_pkg::*;
#(
    parameter int N_CORES       = 1,
    parameter int N_THREADS     = 8,
    parameter int N_THREADS_MSB = msb(N_THREADS - 1)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [N_THREADS_MSB:0]      ts_rd_num,
    output logic [THREAD_STATE_MSB:0]   ts_rd,
    input  logic                        cpu_wr_en,
    input  logic [N_THREADS_MSB:0]      cpu_wr_num,
    input  logic [THREAD_STATE_MSB:0]   cpu_wr_state,
    input  logic                        unit_wr_en,
    input  logic [N_THREADS_MSB:0]      unit_wr_num,
    input  logic [THREAD_STATE_MSB:0]   unit_wr_state,
    output logic                        unit_wr_rdy,
    output logic [N_THREADS_MSB:0]      rdrdy_num,
    output logic                        rdrdy_valid,
    input  logic                        rdrdy_ack,
    output logic                        init_done
);

    logic [THREAD_STATE_MSB:0] r_mem [N_THREADS];

    logic [N_THREADS_MSB:0]    r_init_cnt, w_init_nxt;
    logic                      r_init_busy, r_init_done;
    logic                      r_held_vld;
    logic [N_THREADS_MSB:0]    r_held_num;
    logic [THREAD_STATE_MSB:0] r_held_state;
    logic [N_THREADS_MSB:0]    r_scan_num, w_scan_nxt, r_rdrdy_num;
    logic                      r_rdrdy_valid;
    logic [THREAD_STATE_MSB:0] r_ts_rd, w_scan_state;

    logic                      w_cpu_wr, w_unit_rdy, w_unit_commit, w_we;
    logic [N_THREADS_MSB:0]    w_wnum;
    logic [THREAD_STATE_MSB:0] w_wdata;

    next_thread_num #(.N_CORES(N_CORES), .N_THREADS(N_THREADS), .N_THREADS_MSB(N_THREADS_MSB))
        u_init_next (.i_num(r_init_cnt), .o_next(w_init_nxt));

    next_thread_num #(.N_CORES(N_CORES), .N_THREADS(N_THREADS), .N_THREADS_MSB(N_THREADS_MSB))
        u_scan_next (.i_num(r_scan_num), .o_next(w_scan_nxt));

    assign w_cpu_wr      = cpu_wr_en & r_init_done;
    assign w_unit_rdy    = r_init_done & ~r_held_vld;
    assign w_unit_commit = r_held_vld & ~w_cpu_wr;

    // Single write port: init, then CPU (never stalls), then the held unit write.
    always_comb begin
        w_we    = 1'b0;
        w_wnum  = r_init_cnt;
        w_wdata = THREAD_STATE_WR_RDY;
        if (r_init_busy) begin
            w_we = 1'b1;
        end else if (w_cpu_wr) begin
            w_we    = 1'b1;
            w_wnum  = cpu_wr_num;
            w_wdata = cpu_wr_state;
        end else if (w_unit_commit) begin
            w_we    = 1'b1;
            w_wnum  = r_held_num;
            w_wdata = r_held_state;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_we && 32'(w_wnum) < N_THREADS)
            r_mem[w_wnum] <= w_wdata;
    end

    assign w_scan_state = (32'(r_scan_num) < N_THREADS) ? r_mem[r_scan_num] : THREAD_STATE_NONE;

    // init_done trails the last init write by one cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_init_cnt  <= '0;
            r_init_busy <= 1'b1;
            r_init_done <= 1'b0;
        end else begin
            if (r_init_busy) begin
                r_init_cnt <= w_init_nxt;
                if (w_init_nxt == '0)
                    r_init_busy <= 1'b0;
            end
            r_init_done <= r_init_done | ~r_init_busy;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_held_vld   <= 1'b0;
            r_held_num   <= '0;
            r_held_state <= '0;
        end else if (w_unit_commit) begin
            r_held_vld <= 1'b0;
        end else if (unit_wr_en && w_unit_rdy) begin
            r_held_vld   <= 1'b1;
            r_held_num   <= unit_wr_num;
            r_held_state <= unit_wr_state;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)
            r_ts_rd <= '0;
        else
            r_ts_rd <= (32'(ts_rd_num) < N_THREADS) ? r_mem[ts_rd_num] : THREAD_STATE_NONE;
    end

    // Scanner parks on a reported thread and resumes past it on ack.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_scan_num    <= '0;
            r_rdrdy_num   <= '0;
            r_rdrdy_valid <= 1'b0;
        end else if (r_rdrdy_valid) begin
            if (rdrdy_ack) begin
                r_rdrdy_valid <= 1'b0;
                r_scan_num    <= w_scan_nxt;
            end
        end else if (r_init_done && w_scan_state == THREAD_STATE_RD_RDY) begin
            r_rdrdy_num   <= r_scan_num;
            r_rdrdy_valid <= 1'b1;
        end else begin
            r_scan_num <= w_scan_nxt;
        end
    end

    assign ts_rd       = r_ts_rd;
    assign unit_wr_rdy = w_unit_rdy;
    assign rdrdy_num   = r_rdrdy_num;
    assign rdrdy_valid = r_rdrdy_valid;
    assign init_done   = r_init_done;

endmodule
